// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
//   Clocked front-end for the combinational mini ALU. A raw GO button is
//   synchronized and debounced. Each clean press latches the switch operands
//   into registers that drive the ALU. After a settle window the 20-bit ALU
//   result is captured for the display. Switch motion therefore never
//   disturbs a held result.
//
// Parameters
//   DEBOUNCE_CYCLES : cycles the synced key must hold a new level (>=1)
//   SETTLE_CYCLES   : cycles between operand latch and result capture (>=1)
//   CNT_W           : width of op_count
//
// Ports
//   clk, rst_n      : system clock, async active-low reset (sync release)
//   switches[9:0]   : [9:6] op1, [5:2] op2, [1] operation, [0] sign
//   key_go_n        : raw GO button, active-low, asynchronous to clk
//   alu_op1/op2     : registered operands to the ALU
//   alu_operation   : registered operation select
//   alu_sign        : registered signed-mode select
//   alu_result      : ALU combinational result
//   disp_result     : captured result for the display encoder
//   result_valid    : disp_result holds a completed operation
//   busy            : operation in flight (FSM in SETTLE); doubles as the
//                     FSM state observation point
//   op_count        : completed operations, wraps modulo 2^CNT_W
//   prev_result     : (only with ALU_SEQ_HISTORY_EN) result captured before
//                     the current disp_result
//
// Configuration macro: ALU_SEQ_HISTORY_EN
//
// Handshake: there is no valid/ready pair. A press event is accepted only in
// IDLE; an event that arrives in SETTLE is dropped, not queued.
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SETTLE_CYCLES   = 2,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [9:0]       switches,
    input  logic             key_go_n,
    output logic [3:0]       alu_op1,
    output logic [3:0]       alu_op2,
    output logic             alu_operation,
    output logic             alu_sign,
    input  logic [19:0]      alu_result,
    output logic [19:0]      disp_result,
    output logic             result_valid,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
`ifdef ALU_SEQ_HISTORY_EN
    ,
    output logic [19:0]      prev_result
`endif
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int ST_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              sync1;
    logic              sync2;
    logic              db_level;
    logic              db_level_d;
    logic [DB_W-1:0]   db_cnt;
    logic              press_evt;
    logic [ST_W-1:0]   settle_cnt;
    logic              latch_en;
    logic              capture_en;

    // Two-flop synchronizer. Reset to the released (high) level so that
    // reset itself never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_go_n;
            sync2 <= sync1;
        end
    end

    // The counter only runs while the synced level disagrees with the
    // accepted level. Any bounce back clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_level   <= 1'b1;
            db_level_d <= 1'b1;
            db_cnt     <= '0;
        end else begin
            db_level_d <= db_level;
            if (sync2 == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                db_level <= sync2;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // One pulse per accepted falling edge of the debounced level. A held
    // button therefore never repeats.
    assign press_evt = db_level_d & ~db_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        latch_en   = 1'b0;
        capture_en = 1'b0;
        case (state)
            IDLE: begin
                if (press_evt) begin
                    latch_en   = 1'b1;
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == ST_W'(SETTLE_CYCLES - 1)) begin
                    capture_en = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == SETTLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op1       <= '0;
            alu_op2       <= '0;
            alu_operation <= 1'b0;
            alu_sign      <= 1'b0;
            settle_cnt    <= '0;
            disp_result   <= '0;
            result_valid  <= 1'b0;
            op_count      <= '0;
        end else begin
            if (latch_en) begin
                alu_op1       <= switches[9:6];
                alu_op2       <= switches[5:2];
                alu_operation <= switches[1];
                alu_sign      <= switches[0];
                settle_cnt    <= '0;
                // disp_result keeps the old value; only the valid flag drops.
                result_valid  <= 1'b0;
            end else if (state == SETTLE) begin
                settle_cnt <= settle_cnt + 1'b1;
            end
            if (capture_en) begin
                disp_result  <= alu_result;
                result_valid <= 1'b1;
                op_count     <= op_count + 1'b1;
            end
        end
    end

`ifdef ALU_SEQ_HISTORY_EN
    // Keeps the result that disp_result held just before each capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          prev_result <= '0;
        else if (capture_en) prev_result <= disp_result;
    end
`else
    // No history register in this build.
`endif

endmodule
